isq_sel: RTL



---
 rtl/isq_sel_pkg.sv | 31 +++
 rtl/isq_sel_if.sv | 14 +
 rtl/isq_sel_prio_enc.sv | 26 ++
 rtl/isq_sel.sv | 106 ++++++++++
 4 files changed

// File: rtl/isq_sel_pkg.sv
// Shared constants for the issue-select stage: default geometry and the
// field offsets of one issue-queue line {idx, val, wat, inst}.
package isq_sel_pkg;

    localparam int ISQ_DEPTH_DEF        = 64;
    localparam int ISQ_IDX_BITS_NUM_DEF = 6;
    localparam int INST_WIDTH_DEF       = 56;
    localparam int ISS_PORT_DEF         = 2;

    // Offsets are functions of the payload width so overridden geometries stay consistent.
    function automatic int wat_bit(input int inst_w);
        return inst_w;
    endfunction

    function automatic int val_bit(input int inst_w);
        return inst_w + 1;
    endfunction

    function automatic int idx_lsb(input int inst_w);
        return inst_w + 2;
    endfunction

    function automatic int line_width(input int inst_w, input int idx_w);
        return inst_w + 2 + idx_w;
    endfunction

    localparam int WAT_BIT = wat_bit(INST_WIDTH_DEF);
    localparam int VAL_BIT = val_bit(INST_WIDTH_DEF);
    localparam int IDX_LSB = idx_lsb(INST_WIDTH_DEF);

endpackage

// File: rtl/isq_sel_if.sv
// Issue-lane bus between the select stage and the execution units.
interface isq_sel_if #(
    parameter int ISS_PORT = 2,
    parameter int IDX_W    = 6,
    parameter int INST_W   = 56
);
    logic [ISS_PORT-1:0]        iss_vld;
    logic [ISS_PORT-1:0]        iss_rdy;
    logic [ISS_PORT*IDX_W-1:0]  iss_idx_flat;
    logic [ISS_PORT*INST_W-1:0] iss_inst_flat;

    modport master (output iss_vld, iss_idx_flat, iss_inst_flat, input iss_rdy);
    modport slave  (input iss_vld, iss_idx_flat, iss_inst_flat, output iss_rdy);
endinterface

// File: rtl/isq_sel_prio_enc.sv
// Lowest-set-bit priority encoder: one-hot grant, binary index and found flag.
module isq_prio_enc #(
    parameter int N = 64,
    parameter int W = 6
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         found
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = W'(i);
            end
        end
    end

endmodule

// File: rtl/isq_sel.sv
// Issue select: picks up to ISS_PORT eligible queue lines, lowest index first,
// loads them into registered lanes and pulses clr_inst_wat back to the queue.
module isq_sel
    import isq_sel_pkg::*;
#(
    parameter int ISQ_DEPTH        = ISQ_DEPTH_DEF,
    parameter int ISQ_IDX_BITS_NUM = ISQ_IDX_BITS_NUM_DEF,
    parameter int INST_WIDTH       = INST_WIDTH_DEF,
    parameter int ISQ_LINE_WIDTH   = INST_WIDTH + 2 + ISQ_IDX_BITS_NUM,
    parameter int ISS_PORT         = ISS_PORT_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [ISQ_LINE_WIDTH*ISQ_DEPTH-1:0] isq_out_flat,
    input  logic [ISQ_DEPTH-1:0]                line_rdy,
    input  logic                                flush,
    isq_sel_if.master                           iss,
    output logic [ISQ_DEPTH-1:0]                clr_inst_wat
);

    localparam int VB = val_bit(INST_WIDTH);
    localparam int WB = wat_bit(INST_WIDTH);
    localparam int IL = idx_lsb(INST_WIDTH);

    logic [ISQ_LINE_WIDTH-1:0]                line [ISQ_DEPTH];
    logic [ISQ_DEPTH-1:0]                     elig;
    logic [ISS_PORT-1:0]                      free;
    logic [ISS_PORT-1:0][ISQ_DEPTH-1:0]       avail;
    logic [ISS_PORT-1:0][ISQ_DEPTH-1:0]       req;
    logic [ISS_PORT-1:0][ISQ_DEPTH-1:0]       pick;
    logic [ISS_PORT-1:0][ISQ_IDX_BITS_NUM-1:0] pick_idx;
    logic [ISS_PORT-1:0]                      found;
    logic [ISQ_DEPTH-1:0]                     clr_next;

    // Lines issued last edge are masked until the queue drops their wat.
    always_comb begin
        for (int i = 0; i < ISQ_DEPTH; i++) begin
            line[i] = isq_out_flat[i*ISQ_LINE_WIDTH +: ISQ_LINE_WIDTH];
            elig[i] = line[i][VB] & line[i][WB] & line_rdy[i] & ~clr_inst_wat[i] & ~flush;
        end
    end

    assign free     = ~iss.iss_vld | iss.iss_rdy;
    assign avail[0] = elig;

    // Stalled lanes present an empty request so they do not consume a candidate.
    for (genvar k = 0; k < ISS_PORT; k++) begin : g_lane
        assign req[k] = free[k] ? avail[k] : '0;

        isq_prio_enc #(
            .N (ISQ_DEPTH),
            .W (ISQ_IDX_BITS_NUM)
        ) u_enc (
            .req    (req[k]),
            .onehot (pick[k]),
            .idx    (pick_idx[k]),
            .found  (found[k])
        );

        if (k < ISS_PORT - 1) begin : g_next
            assign avail[k+1] = avail[k] & ~pick[k];
        end
    end

    always_comb begin
        clr_next = '0;
        for (int k = 0; k < ISS_PORT; k++) begin
            clr_next |= pick[k];
        end
    end

    // NOTE: state registers use non-blocking assignments so every lane sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss.iss_vld       <= '0;
            iss.iss_idx_flat  <= '0;
            iss.iss_inst_flat <= '0;
            clr_inst_wat      <= '0;
        end else begin
            clr_inst_wat <= flush ? '0 : clr_next;
            for (int k = 0; k < ISS_PORT; k++) begin
                if (flush) begin
                    iss.iss_vld[k] <= 1'b0;
                end else if (free[k]) begin
                    iss.iss_vld[k] <= found[k];
                    if (found[k]) begin
                        iss.iss_idx_flat[k*ISQ_IDX_BITS_NUM +: ISQ_IDX_BITS_NUM] <= pick_idx[k];
                        iss.iss_inst_flat[k*INST_WIDTH +: INST_WIDTH] <= line[pick_idx[k]][INST_WIDTH-1:0];
                    end
                end
            end
        end
    end

    // The embedded idx field is redundant with the line position.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < ISQ_DEPTH; i++) begin
                if (line[i][VB]) begin
                    assert (line[i][IL +: ISQ_IDX_BITS_NUM] == ISQ_IDX_BITS_NUM'(i));
                end
            end
        end
    end

endmodule
